mem_accumulator: RTL and testbench

Parametrised memory-reduction engine: on a Start command it reads Count consecutive words from a single-port synchronous memory beginning at BaseAddr. It reduces them with a selectable operation (wrapping sum, saturating sum, unsigned max, unsigned min). It writes the result back to DestAddr and signals completion on Ready. It generalises the fixed-width, fixed-depth accumulate-and-write-back datapath with its FSM into one block with a start/length handshake, selectable modes and an overflow flag.

---
 rtl/mem_accumulator.sv | 150 +++++++++++++++
 tb/tb_mem_accumulator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_accumulator.sv
// Memory-reduction engine: reads Count words from BaseAddr, reduces them
// (wrap sum, sat sum, max, min) and writes the result to DestAddr.
// Ports:
//   Clock, Reset        clock, async active-high reset
//   Start               command strobe, accepted only when idle
//   BaseAddr, Count     read window (wraps past top address)
//   DestAddr, Mode      result address, reduction select
//   Address             memory address (0 when no strobe)
//   ReadEnable          memory read strobe
//   WriteEnable         memory write strobe
//   DataIN              write data, always the accumulator
//   DataOut             memory read data, valid cycle after ReadEnable
//   Busy, Ready         command in flight / last command done
//   Overflow            last result wrapped or clamped
module mem_accumulator #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [ADDR_W:0]   Count,
  input  logic [ADDR_W-1:0] DestAddr,
  input  logic [1:0]        Mode,
  output logic [ADDR_W-1:0] Address,
  output logic              ReadEnable,
  output logic              WriteEnable,
  output logic [DATA_W-1:0] DataIN,
  input  logic [DATA_W-1:0] DataOut,
  output logic              Busy,
  output logic              Ready,
  output logic              Overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_ACC,
    S_WRITE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W-1:0]   r_dest;
  logic [1:0]          r_mode;
  logic [ADDR_W:0]     r_idx;
  logic [DATA_W-1:0]   r_acc;
  logic                r_ovf;
  logic                r_busy;
  logic                r_ready;
  logic                r_wr;

  logic                w_accept;
  logic [ADDR_W:0]     w_idx_inc;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W-1:0]   w_comb;
  logic                w_comb_ovf;

  // Busy/Ready/write strobe are registered one cycle behind the state,
  // so the tail cycle after WRITE (state already IDLE) still reads busy
  // and must not accept a new command.
  assign w_accept  = (r_state == S_IDLE) && !r_busy && Start;
  assign w_idx_inc = r_idx + 1'b1;
  assign w_sum     = {1'b0, r_acc} + {1'b0, DataOut};

  always_comb begin
    w_comb     = r_acc;
    w_comb_ovf = 1'b0;
    unique case (r_mode)
      2'b00: begin
        w_comb     = w_sum[DATA_W-1:0];
        w_comb_ovf = w_sum[DATA_W];
      end
      2'b01: begin
        w_comb     = w_sum[DATA_W] ? '1 : w_sum[DATA_W-1:0];
        w_comb_ovf = w_sum[DATA_W];
      end
      2'b10: w_comb = (DataOut > r_acc) ? DataOut : r_acc;
      2'b11: w_comb = (DataOut < r_acc) ? DataOut : r_acc;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_next = (Count == '0) ? S_WRITE : S_READ;
      end
      S_READ:  w_next = S_ACC;
      S_ACC:   w_next = (w_idx_inc < r_count) ? S_READ : S_WRITE;
      S_WRITE: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ReadEnable  = (r_state == S_READ);
    WriteEnable = r_wr;
    Address     = '0;
    if (r_state == S_READ)
      Address = r_base + r_idx[ADDR_W-1:0];
    else if (r_wr)
      Address = r_dest;
    DataIN   = r_acc;
    Busy     = r_busy;
    Ready    = r_ready;
    Overflow = r_ovf;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_count <= '0;
      r_dest  <= '0;
      r_mode  <= '0;
      r_idx   <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (r_state != S_IDLE);
      r_wr    <= (r_state == S_WRITE);
      if (r_wr)
        r_ready <= 1'b1;
      if (w_accept) begin
        r_base  <= BaseAddr;
        r_count <= Count;
        r_dest  <= DestAddr;
        r_mode  <= Mode;
        r_idx   <= '0;
        r_acc   <= (Mode == 2'b11) ? '1 : '0;
        r_ovf   <= 1'b0;
        r_ready <= 1'b0;
      end
      if (r_state == S_ACC) begin
        r_acc <= w_comb;
        r_ovf <= r_ovf | w_comb_ovf;
        r_idx <= w_idx_inc;
      end
    end
  end

endmodule

// File: tb/tb_mem_accumulator.sv
// Bench for mem_accumulator: behavioural memory plus a plain-arithmetic
// reduction model; directed cases followed by randomized commands.
module tb_mem_accumulator;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [4:0]  BaseAddr = '0;
  logic [5:0]  Count = '0;
  logic [4:0]  DestAddr = '0;
  logic [1:0]  Mode = '0;
  logic [4:0]  Address;
  logic        ReadEnable;
  logic        WriteEnable;
  logic [15:0] DataIN;
  logic [15:0] DataOut;
  logic        Busy;
  logic        Ready;
  logic        Overflow;

  logic        ld_en = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [15:0] mem [32];
  logic [4:0]  rd_log [$];
  int          wr_cnt = 0;
  int          wr_addr = 0;
  int          both_cnt = 0;

  int checks = 0;
  int errors = 0;

  mem_accumulator #(.DATA_W(16), .ADDR_W(5)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .BaseAddr    (BaseAddr),
    .Count       (Count),
    .DestAddr    (DestAddr),
    .Mode        (Mode),
    .Address     (Address),
    .ReadEnable  (ReadEnable),
    .WriteEnable (WriteEnable),
    .DataIN      (DataIN),
    .DataOut     (DataOut),
    .Busy        (Busy),
    .Ready       (Ready),
    .Overflow    (Overflow)
  );

  always #5 Clock = ~Clock;

  // Synchronous single-port memory and strobe monitor.
  always @(posedge Clock) begin
    if (ld_en) mem[ld_addr] = ld_data;
    if (ReadEnable) begin
      DataOut <= mem[Address];
      rd_log.push_back(Address);
    end
    if (WriteEnable) begin
      mem[Address] = DataIN;
      wr_cnt++;
      wr_addr = int'(Address);
    end
    if (ReadEnable && WriteEnable) both_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int a, input int d);
    @(negedge Clock);
    ld_en   = 1'b1;
    ld_addr = 5'(a);
    ld_data = 16'(d);
    @(negedge Clock);
    ld_en = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_re"}, 32'(ReadEnable), 0);
    chk({tag, "_we"}, 32'(WriteEnable), 0);
    chk({tag, "_addr"}, 32'(Address), 0);
    chk({tag, "_din"}, 32'(DataIN), 0);
    chk({tag, "_busy"}, 32'(Busy), 0);
    chk({tag, "_ready"}, 32'(Ready), 0);
    chk({tag, "_ovf"}, 32'(Overflow), 0);
  endtask

  task automatic run_cmd(input string tag, input int base, input int cnt,
                         input int dest, input int mode, input bit pulse);
    int snap [32];
    int acc;
    int w;
    bit ov;
    int n;
    int r0;
    int w0;
    int bad;
    for (int i = 0; i < 32; i++) snap[i] = int'(mem[i]);
    acc = (mode == 3) ? 65535 : 0;
    ov  = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      w = snap[(base + i) % 32];
      case (mode)
        0: begin
          acc = acc + w;
          if (acc > 65535) begin acc = acc - 65536; ov = 1'b1; end
        end
        1: begin
          acc = acc + w;
          if (acc > 65535) begin acc = 65535; ov = 1'b1; end
        end
        2: if (w > acc) acc = w;
        default: if (w < acc) acc = w;
      endcase
    end
    r0 = rd_log.size();
    w0 = wr_cnt;
    @(negedge Clock);
    BaseAddr = 5'(base);
    Count    = 6'(cnt);
    DestAddr = 5'(dest);
    Mode     = 2'(mode);
    Start    = 1'b1;
    @(posedge Clock);
    #1 Start = 1'b0;
    n = 0;
    while (n < 200) begin
      @(posedge Clock);
      n++;
      #1;
      if (pulse && n == 3) begin
        BaseAddr = 5'(base + 7);
        Count    = 6'd1;
        DestAddr = 5'(dest + 1);
        Mode     = ~2'(mode);
        Start    = 1'b1;
      end else begin
        Start = 1'b0;
      end
      if (Ready) break;
    end
    Start = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'(2 * cnt + 2));
    chk({tag, "_writes"}, 32'(wr_cnt - w0), 1);
    chk({tag, "_waddr"}, 32'(wr_addr), 32'(dest));
    chk({tag, "_result"}, 32'(mem[dest]), 32'(acc));
    chk({tag, "_ovf"}, 32'(Overflow), 32'(ov));
    chk({tag, "_busy"}, 32'(Busy), 0);
    chk({tag, "_nreads"}, 32'(rd_log.size() - r0), 32'(cnt));
    bad = -1;
    for (int i = 0; i < cnt && r0 + i < rd_log.size(); i++)
      if (int'(rd_log[r0 + i]) != (base + i) % 32 && bad < 0) bad = i;
    chk({tag, "_raddr_order"}, 32'(bad), 32'(-1));
  endtask

  initial begin
    int found;
    int w0;
    for (int i = 0; i < 32; i++) load(i, 0);
    repeat (2) @(negedge Clock);
    chk_idle_outputs("reset_hold");
    Reset = 1'b0;
    @(negedge Clock);
    chk_idle_outputs("after_reset");

    load(0, 1); load(1, 2); load(2, 3); load(3, 4);
    run_cmd("sum4", 0, 4, 10, 0, 1'b0);
    chk("sum4_literal", 32'(mem[10]), 10);

    load(4, 16'hFFF0); load(5, 16'h0020);
    run_cmd("sat", 4, 2, 11, 1, 1'b0);
    chk("sat_literal", 32'(mem[11]), 32'h0000_FFFF);
    run_cmd("wrap", 4, 2, 12, 0, 1'b0);
    chk("wrap_literal", 32'(mem[12]), 32'h0000_0010);

    load(6, 16'h0005); load(7, 16'h8000); load(8, 16'h7FFF);
    run_cmd("max", 6, 3, 13, 2, 1'b0);
    chk("max_literal", 32'(mem[13]), 32'h0000_8000);
    run_cmd("min", 6, 3, 14, 3, 1'b0);
    chk("min_literal", 32'(mem[14]), 32'h0000_0005);

    load(30, 100); load(31, 200);
    run_cmd("wrap_addr", 30, 4, 15, 0, 1'b0);
    run_cmd("count0_min", 0, 0, 16, 3, 1'b0);
    chk("count0_literal", 32'(mem[16]), 32'h0000_FFFF);

    run_cmd("mid_start", 0, 4, 17, 0, 1'b1);

    // Reset while the third read strobe is up.
    w0 = wr_cnt;
    found = 0;
    @(negedge Clock);
    BaseAddr = 5'd0; Count = 6'd8; DestAddr = 5'd20; Mode = 2'b00;
    Start = 1'b1;
    @(posedge Clock);
    #1 Start = 1'b0;
    w0 = rd_log.size();
    for (int k = 0; k < 40; k++) begin
      @(negedge Clock);
      if (ReadEnable && rd_log.size() - w0 == 2) begin
        found = 1;
        break;
      end
    end
    chk("rst_third_read_seen", 32'(found), 1);
    w0 = wr_cnt;
    Reset = 1'b1;
    #1;
    chk_idle_outputs("mid_reset");
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    repeat (4) @(negedge Clock);
    chk("mid_reset_nowrite", 32'(wr_cnt - w0), 0);
    chk("mid_reset_idle", 32'(Busy), 0);
    run_cmd("post_reset", 0, 4, 18, 1, 1'b0);

    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < 32; i++)
        load(i, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                            : int'($urandom_range(0, 65535)));
      run_cmd("rand", int'($urandom_range(0, 31)), int'($urandom_range(0, 32)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
    end

    chk("no_overlap", 32'(both_cnt), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
